// File: rtl/dtw_sdtw_stream_engine.sv
// Streaming subsequence-DTW engine: a linear systolic array of PEs, one per query sample,
// fed by a valid/ready reference stream, tracking the minimum last-row cost and its position.
module dtw_sdtw_stream_engine #(
   parameter int WIDTH    = 16,
   parameter int SQG_SIZE = 64,
   parameter int POS_W    = 32,
   parameter int QLEN_W   = $clog2(SQG_SIZE + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [QLEN_W-1:0] cfg_qlen,
   input  logic [WIDTH-1:0]  cfg_thresh,
   input  logic              q_valid,
   input  logic [WIDTH-1:0]  q_data,
   output logic              q_ready,
   input  logic              r_valid,
   input  logic [WIDTH-1:0]  r_data,
   input  logic              r_last,
   output logic              r_ready,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  min_val,
   output logic [POS_W-1:0]  min_pos,
   output logic              hit
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [WIDTH-1:0]  ONES = '1;
   localparam logic [QLEN_W-1:0] MAXQ = QLEN_W'(SQG_SIZE);

   state_t             state_q, state_d;
   logic [QLEN_W-1:0]  qlen_q, qlen_d, cnt_q, cnt_d, qlen_clamped;
   logic [WIDTH-1:0]   thresh_q, thresh_d, min_val_q, min_val_d;
   logic [POS_W-1:0]   pos_q, pos_d, min_pos_q, min_pos_d;
   logic               hit_q, hit_d, adv;

   logic [WIDTH-1:0]   qm_q [SQG_SIZE];
   logic [WIDTH-1:0]   qm_d [SQG_SIZE];
   logic [WIDTH-1:0]   r_q  [SQG_SIZE];
   logic [WIDTH-1:0]   r_d  [SQG_SIZE];
   logic               v_q  [SQG_SIZE];
   logic               v_d  [SQG_SIZE];
   logic [WIDTH-1:0]   d_q  [SQG_SIZE];
   logic [WIDTH-1:0]   d_d  [SQG_SIZE];
   logic [WIDTH-1:0]   dp_q [SQG_SIZE];
   logic [WIDTH-1:0]   dp_d [SQG_SIZE];

   logic               src_v  [SQG_SIZE];
   logic [WIDTH-1:0]   src_r  [SQG_SIZE];
   logic [WIDTH-1:0]   up_d   [SQG_SIZE];
   logic [WIDTH-1:0]   up_dp  [SQG_SIZE];
   logic [WIDTH-1:0]   cost   [SQG_SIZE];
   logic [WIDTH-1:0]   mn     [SQG_SIZE];
   logic [WIDTH:0]     sum    [SQG_SIZE];
   logic [WIDTH-1:0]   pe_new [SQG_SIZE];

   assign qlen_clamped = (cfg_qlen > MAXQ) ? MAXQ : cfg_qlen;

   // PE i sees D[i-1][j] and D[i-1][j-1] from its upstream neighbour; row 0 is the free-start zero row.
   always_comb begin
      src_v[0] = (state_q == S_RUN);
      src_r[0] = r_data;
      up_d[0]  = '0;
      up_dp[0] = '0;
      for (int i = 1; i < SQG_SIZE; i++) begin
         src_v[i] = v_q[i-1];
         src_r[i] = r_q[i-1];
         up_d[i]  = d_q[i-1];
         up_dp[i] = dp_q[i-1];
      end
      for (int i = 0; i < SQG_SIZE; i++) begin
         cost[i] = (qm_q[i] > src_r[i]) ? (qm_q[i] - src_r[i]) : (src_r[i] - qm_q[i]);
         mn[i]   = up_d[i];
         if (d_q[i] < mn[i]) mn[i] = d_q[i];
         if (up_dp[i] < mn[i]) mn[i] = up_dp[i];
         sum[i]    = {1'b0, cost[i]} + {1'b0, mn[i]};
         pe_new[i] = sum[i][WIDTH] ? ONES : sum[i][WIDTH-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      qlen_d    = qlen_q;
      thresh_d  = thresh_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      min_val_d = min_val_q;
      min_pos_d = min_pos_q;
      adv       = 1'b0;
      qm_d      = qm_q;
      r_d       = r_q;
      v_d       = v_q;
      d_d       = d_q;
      dp_d      = dp_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               qlen_d    = qlen_clamped;
               thresh_d  = cfg_thresh;
               cnt_d     = '0;
               pos_d     = '0;
               min_val_d = ONES;
               min_pos_d = '0;
               for (int i = 0; i < SQG_SIZE; i++) begin
                  v_d[i]  = 1'b0;
                  d_d[i]  = ONES;
                  dp_d[i] = ONES;
               end
               state_d = (qlen_clamped == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (q_valid) begin
               for (int i = 0; i < SQG_SIZE; i++) begin
                  if (cnt_q == QLEN_W'(i)) qm_d[i] = q_data;
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == qlen_q - 1'b1) begin
                  cnt_d   = '0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (r_valid) begin
               adv = 1'b1;
               if (r_last) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            adv   = 1'b1;
            cnt_d = cnt_q + 1'b1;
            // The last column reaches PE L on drain advance L-2; L=1 still spends one drain cycle.
            if (({1'b0, cnt_q} + (QLEN_W+1)'(2)) >= {1'b0, qlen_q}) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         for (int i = 0; i < SQG_SIZE; i++) begin
            if (QLEN_W'(i) < qlen_q) begin
               r_d[i] = src_r[i];
               v_d[i] = src_v[i];
               if (src_v[i]) begin
                  d_d[i]  = pe_new[i];
                  dp_d[i] = d_q[i];
                  if (QLEN_W'(i + 1) == qlen_q) begin
                     if (pe_new[i] < min_val_q) begin
                        min_val_d = pe_new[i];
                        min_pos_d = pos_q;
                     end
                     pos_d = pos_q + 1'b1;
                  end
               end
            end
         end
      end

      hit_d = (min_val_d < thresh_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         qlen_q    <= '0;
         thresh_q  <= '0;
         cnt_q     <= '0;
         pos_q     <= '0;
         min_val_q <= ONES;
         min_pos_q <= '0;
         hit_q     <= 1'b0;
         for (int i = 0; i < SQG_SIZE; i++) begin
            qm_q[i] <= '0;
            r_q[i]  <= '0;
            v_q[i]  <= 1'b0;
            d_q[i]  <= ONES;
            dp_q[i] <= ONES;
         end
      end else begin
         state_q   <= state_d;
         qlen_q    <= qlen_d;
         thresh_q  <= thresh_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         min_val_q <= min_val_d;
         min_pos_q <= min_pos_d;
         hit_q     <= hit_d;
         qm_q      <= qm_d;
         r_q       <= r_d;
         v_q       <= v_d;
         d_q       <= d_d;
         dp_q      <= dp_d;
      end
   end

   assign q_ready = (state_q == S_LOAD);
   assign r_ready = (state_q == S_RUN);
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign min_val = min_val_q;
   assign min_pos = min_pos_q;
   assign hit     = hit_q;

endmodule
